// File: rtl/lc3b_mem_pkg.sv
// rtl/lc3b_mem_pkg.sv - shared types and constants for the LC-3b memory sequencer
package lc3b_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic DATA_SIZE_BYTE = 1'b0;
    localparam logic DATA_SIZE_WORD = 1'b1;
    localparam logic R_W_READ       = 1'b0;
    localparam logic R_W_WRITE      = 1'b1;

    localparam int CNT_W = 4;

    // Byte lanes touched by a write: words hit both, bytes pick the lane from MAR[0].
    function automatic logic [1:0] byte_en(input logic size, input logic a0);
        if (size == DATA_SIZE_WORD) begin
            return 2'b11;
        end
        return a0 ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/lc3b_mem_ctrl_if.sv
// rtl/lc3b_mem_ctrl_if.sv - datapath-to-memory handshake bundle (UNALIGNED only with LC3B_UNALIGNED_TRAP_EN)
interface lc3b_mem_ctrl_if;
    logic        MIO_EN;
    logic        R_W;
    logic        DATA_SIZE;
    logic [15:0] MAR;
    logic [15:0] MDR_in;
    logic [15:0] MEM_out;
    logic        R;
`ifdef LC3B_UNALIGNED_TRAP_EN
    logic        UNALIGNED;

    modport master (output MIO_EN, R_W, DATA_SIZE, MAR, MDR_in,
                    input  MEM_out, R, UNALIGNED);
    modport slave  (input  MIO_EN, R_W, DATA_SIZE, MAR, MDR_in,
                    output MEM_out, R, UNALIGNED);
`else
    modport master (output MIO_EN, R_W, DATA_SIZE, MAR, MDR_in,
                    input  MEM_out, R);
    modport slave  (input  MIO_EN, R_W, DATA_SIZE, MAR, MDR_in,
                    output MEM_out, R);
`endif
endinterface

// File: rtl/lc3b_mem_array.sv
// rtl/lc3b_mem_array.sv - 16-bit word RAM with byte write enables and a registered read port
module lc3b_mem_array #(
    parameter int ADDR_WIDTH = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            i_we,
    input  logic [15:0]           i_wdata,
    input  logic                  i_rd_en,
    output logic [15:0]           o_rdata
);

    logic [15:0] r_mem [2**ADDR_WIDTH];
    logic [15:0] r_rdata;

    // Contents are deliberately left unreset; only the read register clears.
    always_ff @(posedge clk) begin
        if (i_we[0]) begin
            r_mem[i_addr][7:0] <= i_wdata[7:0];
        end
        if (i_we[1]) begin
            r_mem[i_addr][15:8] <= i_wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdata <= 16'h0000;
        end else if (i_rd_en) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/lc3b_mem_ctrl.sv
// rtl/lc3b_mem_ctrl.sv - fixed-latency LC-3b memory sequencer; LC3B_UNALIGNED_TRAP_EN adds the unaligned-word trap
module lc3b_mem_ctrl
    import lc3b_mem_pkg::*;
#(
    parameter int MEM_LATENCY = 5,
    parameter int ADDR_WIDTH  = 15
) (
    input  logic            clk,
    input  logic            rst,
    lc3b_mem_ctrl_if.slave  bus
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic                  r_rw;
    logic                  r_size;
    logic                  r_a0;
    logic [15:0]           r_wdata;
    logic                  r_r;
    logic                  w_start;
    logic                  w_trap;
    logic                  w_complete;
    logic                  w_live;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic                  w_rw;
    logic                  w_size;
    logic                  w_a0;
    logic [15:0]           w_wd;
    logic [15:0]           w_wdata;
    logic [1:0]            w_we;
    logic                  w_rd_en;
    logic [15:0]           w_rdata;

    assign w_start = (r_state == IDLE) && bus.MIO_EN;

`ifdef LC3B_UNALIGNED_TRAP_EN
    logic r_unal;
    assign w_trap = w_start && (bus.DATA_SIZE == DATA_SIZE_WORD) && bus.MAR[0];
    assign bus.UNALIGNED = r_unal;
`else
    assign w_trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The counter is loaded with MEM_LATENCY-1 and completion fires on the edge where it reaches zero.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_live      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start) begin
                    if (w_trap) begin
                        w_state_nxt = DONE;
                    end else if (MEM_LATENCY == 1) begin
                        w_complete  = 1'b1;
                        w_live      = 1'b1;
                        w_state_nxt = DONE;
                    end else begin
                        w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!bus.MIO_EN) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end else if (r_cnt <= CNT_W'(1)) begin
                    w_cnt_nxt   = '0;
                    w_complete  = 1'b1;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_addr  <= '0;
            r_rw    <= R_W_READ;
            r_size  <= DATA_SIZE_BYTE;
            r_a0    <= 1'b0;
            r_wdata <= 16'h0000;
            r_r     <= 1'b0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_r   <= w_complete;
            if (w_start) begin
                r_addr  <= bus.MAR[ADDR_WIDTH:1];
                r_rw    <= bus.R_W;
                r_size  <= bus.DATA_SIZE;
                r_a0    <= bus.MAR[0];
                r_wdata <= bus.MDR_in;
            end
        end
    end

`ifdef LC3B_UNALIGNED_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_unal <= 1'b0;
        end else begin
            r_unal <= w_trap;
        end
    end
`endif

    // Single-cycle latency completes in IDLE, before the capture registers hold the request.
    assign w_addr  = w_live ? bus.MAR[ADDR_WIDTH:1] : r_addr;
    assign w_rw    = w_live ? bus.R_W               : r_rw;
    assign w_size  = w_live ? bus.DATA_SIZE         : r_size;
    assign w_a0    = w_live ? bus.MAR[0]            : r_a0;
    assign w_wd    = w_live ? bus.MDR_in            : r_wdata;

    assign w_wdata = (w_size == DATA_SIZE_WORD) ? w_wd : {w_wd[7:0], w_wd[7:0]};
    assign w_we    = (w_complete && !rst && (w_rw == R_W_WRITE)) ? byte_en(w_size, w_a0) : 2'b00;
    assign w_rd_en = w_complete && !rst && (w_rw == R_W_READ);

    lc3b_mem_array #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_addr  (w_addr),
        .i_we    (w_we),
        .i_wdata (w_wdata),
        .i_rd_en (w_rd_en),
        .o_rdata (w_rdata)
    );

    assign bus.MEM_out = w_rdata;
    assign bus.R       = r_r;

endmodule

// File: doc/lc3b_mem_ctrl.md
Name: lc3b_mem_ctrl

Overview:
Memory access sequencer for the LC-3b datapath. It accepts MIO_EN/R_W/DATA_SIZE/MAR/MDR from the datapath and runs a fixed-latency access on a byte-enabled 16-bit word memory. It raises the ready flag R that the control FSM polls in memory microstates, and returns the read word for MDR.

Parameters:
MEM_LATENCY, 5, cycles from first MIO_EN-high cycle to R-high cycle; legal range 1..15
ADDR_WIDTH, 15, word-address bits taken from MAR[ADDR_WIDTH:1]; higher MAR bits ignored, so addresses alias

Ports:
clk  input  1  system clock
rst  input  1  reset, synchronous, active-high
MIO_EN  input  1  memory access request; held high by control until R
R_W  input  1  0 = read, 1 = write
DATA_SIZE  input  1  0 = byte, 1 = word
MAR  input  16  access address
MDR_in  input  16  write data from MDR
MEM_out  output  16  read word to MDR input mux
R  output  1  access complete, registered

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, R=0, MEM_out=0, counter=0. Array contents are not reset. Reset during an access aborts it and commits no write.
- FSM states: IDLE, BUSY, DONE.
  - IDLE with MIO_EN=1 in cycle 0: latch MAR, R_W, DATA_SIZE, MDR_in; counter <= MEM_LATENCY-1; go to BUSY. If MEM_LATENCY=1, go straight to completion.
  - BUSY: counter decrements each cycle. On the edge where counter==0 (end of cycle MEM_LATENCY-1), do the completion, set R=1 and go to DONE.
  - Completion: a read samples the word into MEM_out; a write commits into the array.
  - DONE (cycle MEM_LATENCY): R=1 for exactly one cycle; MIO_EN is ignored; go to IDLE. R=0 next cycle.
  - If MIO_EN is still high in the IDLE cycle after DONE, a new access starts there (back-to-back allowed).
- Inputs are captured at start only; changes to MAR/R_W/DATA_SIZE/MDR_in during BUSY are ignored.
- Abort: MIO_EN=0 in any BUSY cycle -> IDLE next cycle, no write, R stays 0, MEM_out unchanged.
- Read: MEM_out = full word at MAR[ADDR_WIDTH:1] regardless of DATA_SIZE (byte select/sign-extend is done in datapath). MEM_out holds until the next completed read.
- Write, word: both bytes <= MDR_in.
- Write, byte: MAR[0]=0 -> low byte <= MDR_in[7:0]; MAR[0]=1 -> high byte <= MDR_in[7:0]; the other byte is unchanged.
- Word access with MAR[0]=1: MAR[0] is ignored and the address is aligned down (unless the feature below is compiled in).

Optional Feature:
Macro LC3B_UNALIGNED_TRAP_EN.
- Defined:
  - Extra output port UNALIGNED (1 bit, reset 0).
  - A word access with MAR[0]=1 accepted in IDLE performs no memory operation. UNALIGNED=1 for exactly cycle 1, then the FSM is in IDLE.
  - R is never raised for that access.
- Undefined: no port; word accesses are aligned down as above.

Decomposition:
- Package lc3b_mem_pkg holds:
  - state enum {IDLE, BUSY, DONE}
  - constants DATA_SIZE_BYTE=0, DATA_SIZE_WORD=1, R_W_READ=0, R_W_WRITE=1
  - counter width constant (4 bits)
- Sub-module lc3b_mem_array: 2^ADDR_WIDTH x 16 synchronous RAM with 2-bit byte write enable and synchronous read. It is instantiated once; the controller holds only the FSM, counter and capture registers.

Test Plan:
1. Preload word 0x1234 at MAR=0x3000; read word with MIO_EN=1 from cycle 0, MEM_LATENCY=5 -> R=0 in cycles 0-4, R=1 only in cycle 5 with MEM_out=0x1234, R=0 in cycle 6.
2. Word write 0xBEEF at 0x4000, then byte write MDR_in=0x00AA at 0x4001, then word read of 0x4000 -> MEM_out=0xAAEF. Byte write 0x0055 at 0x4000 followed by read -> 0xAA55.
3. Start a write of 0xFFFF at 0x5000 (old 0x0000); drop MIO_EN in cycle 2 -> R never rises; a subsequent read returns 0x0000. Same for rst=1 in cycle 3.
4. Hold MIO_EN high across two consecutive reads (0x3000, then MAR changed to 0x3002 in the DONE cycle) -> R pulses in cycles 5 and 11; second MEM_out is the word at 0x3002.
5. MEM_LATENCY=1: read 0x3000 -> R=1 in cycle 1 with correct data. Changing MAR mid-access at MEM_LATENCY=5 does not affect the returned word.
6. With LC3B_UNALIGNED_TRAP_EN: word read at 0x3001 -> UNALIGNED=1 in cycle 1 only, R stays 0, memory unchanged. Without the macro: the same access returns the word at 0x3000 in cycle 5.
